// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window engine: default sizes,
// derived arithmetic widths, FSM state type and the output clamp.
package conv_pkg;

   localparam int unsigned ImgSizeDef = 256;
   localparam int unsigned OutSizeDef = ImgSizeDef - 2;
   localparam int unsigned AddrWDef   = 16;
   localparam int unsigned CoefWDef   = 8;
   localparam int unsigned ShiftDef   = 4;

   localparam int unsigned PixW   = 8;
   localparam int unsigned Taps   = 9;
   // Nine products can grow the magnitude by at most 9x, which 4 extra bits cover.
   localparam int unsigned GuardW = 4;
   // Common width handed to the clamp so it works for any coefficient width.
   localparam int unsigned ClampW = 32;

   // Unsigned 8-bit pixel (as 9-bit signed) times signed coefficient.
   function automatic int unsigned prodWidth(input int unsigned coefW);
      return PixW + 1 + coefW;
   endfunction

   function automatic int unsigned sumWidth(input int unsigned coefW);
      return prodWidth(coefW) + GuardW;
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } convStateT;

   // Saturate a signed value into the 0..255 pixel range.
   function automatic logic [PixW-1:0] clampPixel(input logic signed [ClampW-1:0] v);
      if (v < 0) begin
         return '0;
      end else if (v > 255) begin
         return 8'hFF;
      end else begin
         return v[PixW-1:0];
      end
   endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Nine signed multipliers feeding an adder tree. Two register stages (products,
// then sum) share one advance enable so a downstream stall freezes both.
module conv_mac_tree
   import conv_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDef,
   parameter int unsigned COEF_W = CoefWDef,
   localparam int unsigned ProdW = prodWidth(COEF_W),
   localparam int unsigned SumW  = sumWidth(COEF_W)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          inValid,
   input  logic [ADDR_W-1:0]             inAddr,
   input  logic [Taps-1:0][PixW-1:0]     pix,
   input  logic [Taps-1:0][COEF_W-1:0]   coef,
   output logic                          prodValid,
   output logic                          sumValid,
   output logic [ADDR_W-1:0]             sumAddr,
   output logic signed [SumW-1:0]        sum
);

   logic signed [ProdW-1:0] prodD [Taps];
   logic signed [ProdW-1:0] prodQ [Taps];
   logic [ADDR_W-1:0]       prodAddr;
   logic signed [SumW-1:0]  pairSum [5];
   logic signed [SumW-1:0]  sumD;

   // Pixels are zero-extended (always non-negative), coefficients sign-extended.
   always_comb begin
      for (int i = 0; i < Taps; i++) begin
         prodD[i] = $signed({{(COEF_W + 1){1'b0}}, pix[i]})
                  * $signed({{(PixW + 1){coef[i][COEF_W-1]}}, coef[i]});
      end
   end

   // S1: register products together with their output index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prodValid <= 1'b0;
         prodAddr  <= '0;
         for (int i = 0; i < Taps; i++) begin
            prodQ[i] <= '0;
         end
      end else if (en) begin
         prodValid <= inValid;
         prodAddr  <= inAddr;
         for (int i = 0; i < Taps; i++) begin
            prodQ[i] <= prodD[i];
         end
      end
   end

   // Balanced adder tree over sign-extended products.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pairSum[i] = $signed({{GuardW{prodQ[2*i][ProdW-1]}}, prodQ[2*i]})
                    + $signed({{GuardW{prodQ[2*i+1][ProdW-1]}}, prodQ[2*i+1]});
      end
      pairSum[4] = $signed({{GuardW{prodQ[8][ProdW-1]}}, prodQ[8]});
      sumD = (pairSum[0] + pairSum[1]) + (pairSum[2] + pairSum[3]) + pairSum[4];
   end

   // S2: register the accumulated sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sumValid <= 1'b0;
         sumAddr  <= '0;
         sum      <= '0;
      end else if (en) begin
         sumValid <= prodValid;
         sumAddr  <= prodAddr;
         sum      <= sumD;
      end
   end

endmodule

// File: rtl/conv_window_engine.sv
// Frame sequencer around the window RAM: sweeps every valid 3x3 window in raster
// order, filters it through the MAC tree, then shifts/clamps and hands each
// pixel downstream over valid/ready.
module conv_window_engine
   import conv_pkg::*;
#(
   parameter int unsigned IMG_SIZE = ImgSizeDef,
   parameter int unsigned ADDR_W   = AddrWDef,
   parameter int unsigned COEF_W   = CoefWDef,
   parameter int unsigned SHIFT    = ShiftDef
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic signed [COEF_W-1:0] k0,
   input  logic signed [COEF_W-1:0] k1,
   input  logic signed [COEF_W-1:0] k2,
   input  logic signed [COEF_W-1:0] k3,
   input  logic signed [COEF_W-1:0] k4,
   input  logic signed [COEF_W-1:0] k5,
   input  logic signed [COEF_W-1:0] k6,
   input  logic signed [COEF_W-1:0] k7,
   input  logic signed [COEF_W-1:0] k8,
   output logic [ADDR_W-1:0]        im_addr,
   input  logic [PixW-1:0]          p0,
   input  logic [PixW-1:0]          p1,
   input  logic [PixW-1:0]          p2,
   input  logic [PixW-1:0]          p3,
   input  logic [PixW-1:0]          p4,
   input  logic [PixW-1:0]          p5,
   input  logic [PixW-1:0]          p6,
   input  logic [PixW-1:0]          p7,
   input  logic [PixW-1:0]          p8,
   output logic [PixW-1:0]          out_pixel,
   output logic [ADDR_W-1:0]        out_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned OutSize = IMG_SIZE - 2;
   localparam int unsigned SumW    = sumWidth(COEF_W);
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(OutSize - 1);

   convStateT                   state;
   logic [ADDR_W-1:0]           row;
   logic [ADDR_W-1:0]           col;
   logic [ADDR_W-1:0]           issueAddr;
   logic [Taps-1:0][COEF_W-1:0] coefQ;
   logic [Taps-1:0][COEF_W-1:0] kIn;
   logic [Taps-1:0][PixW-1:0]   pix;

   logic                        stall;
   logic                        issue;
   logic                        lastAccept;
   logic                        prodValid;
   logic                        sumValid;
   logic [ADDR_W-1:0]           sumAddr;
   logic signed [SumW-1:0]      sum;
   logic signed [SumW-1:0]      shifted;
   logic signed [ClampW-1:0]    shiftedExt;

   assign kIn = {k8, k7, k6, k5, k4, k3, k2, k1, k0};
   assign pix = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

   // A held output freezes every stage, the counters and the RAM address.
   assign stall      = out_valid && !out_ready;
   assign issue      = (state == StRun) && !stall;
   // Last word leaving with nothing left behind it in the pipeline.
   assign lastAccept = out_valid && out_ready && !prodValid && !sumValid;

   // Frame FSM: kernel latch, raster window counters and busy/done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         row       <= '0;
         col       <= '0;
         im_addr   <= '0;
         issueAddr <= '0;
         coefQ     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  coefQ     <= kIn;
                  row       <= '0;
                  col       <= '0;
                  im_addr   <= '0;
                  issueAddr <= '0;
                  busy      <= 1'b1;
                  state     <= StRun;
               end
            end
            StRun: begin
               if (!stall) begin
                  issueAddr <= issueAddr + ADDR_W'(1);
                  if (col == LastIdx) begin
                     col <= '0;
                     if (row == LastIdx) begin
                        row     <= '0;
                        im_addr <= '0;
                        state   <= StDrain;
                     end else begin
                        row     <= row + ADDR_W'(1);
                        // Skip the two columns with no full window to the next row start.
                        im_addr <= im_addr + ADDR_W'(3);
                     end
                  end else begin
                     col     <= col + ADDR_W'(1);
                     im_addr <= im_addr + ADDR_W'(1);
                  end
               end
            end
            StDrain: begin
               if (lastAccept) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   conv_mac_tree #(
      .ADDR_W (ADDR_W),
      .COEF_W (COEF_W)
   ) uMacTree (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (!stall),
      .inValid   (issue),
      .inAddr    (issueAddr),
      .pix       (pix),
      .coef      (coefQ),
      .prodValid (prodValid),
      .sumValid  (sumValid),
      .sumAddr   (sumAddr),
      .sum       (sum)
   );

   // Arithmetic shift floors toward minus infinity before clamping.
   always_comb begin
      shifted    = sum >>> SHIFT;
      shiftedExt = $signed({{(ClampW - SumW){shifted[SumW-1]}}, shifted});
   end

   // S3: output register, held while the consumer is not ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_addr  <= '0;
      end else if (!stall) begin
         out_valid <= sumValid;
         if (sumValid) begin
            out_pixel <= clampPixel(shiftedExt);
            out_addr  <= sumAddr;
         end
      end
   end

endmodule
